// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// writeback, with a destination-register busy scoreboard and a saturating contention counter.
module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [ADDR_W-1:0]        a_addr,
   input  logic [DATA_W-1:0]        a_data,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [ADDR_W-1:0]        b_addr,
   input  logic [DATA_W-1:0]        b_data,
   input  logic                     rsv_valid,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [(1<<ADDR_W)-1:0]   busy,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [CNT_W-1:0]         contention_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic              rr_q, rr_d;
   logic              grantA, grantB, accept, bothValid;
   logic [ADDR_W-1:0] accAddr;
   logic [DATA_W-1:0] accData;

   logic              wrEn_q, wrEn_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic [DATA_W-1:0] wrData_q, wrData_d;
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign bothValid = a_valid && b_valid;

   // rr_q names the requester that wins a tie; a lone requester is always granted.
   always_comb begin
      grantA = 1'b0;
      grantB = 1'b0;
      if (!reset) begin
         if (a_valid && (!b_valid || !rr_q)) begin
            grantA = 1'b1;
         end else if (b_valid) begin
            grantB = 1'b1;
         end
      end
   end

   assign a_ready = grantA;
   assign b_ready = grantB;
   assign accept  = grantA || grantB;
   assign accAddr = grantA ? a_addr : b_addr;
   assign accData = grantA ? a_data : b_data;

   always_comb begin
      rr_d = rr_q;
      if (bothValid) begin
         rr_d = ~rr_q;
      end
   end

   always_comb begin
      wrEn_d   = accept && (accAddr != '0);
      wrAddr_d = wrAddr_q;
      wrData_d = wrData_q;
      if (accept) begin
         wrAddr_d = accAddr;
         wrData_d = accData;
      end
   end

   // A reservation on the same edge as a clearing write wins: it belongs to a newer instruction.
   always_comb begin
      busy_d = busy_q;
      if (accept) begin
         busy_d[accAddr] = 1'b0;
      end
      if (rsv_valid && (rsv_addr != '0)) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bothValid && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q     <= 1'b0;
         wrEn_q   <= 1'b0;
         wrAddr_q <= '0;
         wrData_q <= '0;
         busy_q   <= '0;
         cnt_q    <= '0;
      end else begin
         rr_q     <= rr_d;
         wrEn_q   <= wrEn_d;
         wrAddr_q <= wrAddr_d;
         wrData_q <= wrData_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign wr_en          = wrEn_q;
   assign wr_addr        = wrAddr_q;
   assign wr_data        = wrData_q;
   assign busy           = busy_q;
   assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter plus hand-written multi-cycle sequences.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset;
   logic        aValid, bValid, rsvValid;
   logic [4:0]  aAddr, bAddr, rsvAddr;
   logic [31:0] aData, bData;
   logic        aReady, bReady, wrEn;
   logic [31:0] busy;
   logic [4:0]  wrAddr;
   logic [31:0] wrData;
   logic [15:0] contentionCnt;

   logic        satAReady, satBReady, satWrEn;
   logic [31:0] satBusy;
   logic [4:0]  satWrAddr;
   logic [31:0] satWrData;
   logic [2:0]  satCnt;

   int testCount = 0;
   int failCount = 0;

   typedef struct {
      logic        rst;
      logic        aV;
      logic [4:0]  aA;
      logic [31:0] aD;
      logic        bV;
      logic [4:0]  bA;
      logic [31:0] bD;
      logic        rV;
      logic [4:0]  rA;
      logic        expAR;
      logic        expBR;
      logic        expWrEn;
      logic [4:0]  expWrAddr;
      logic [31:0] expWrData;
      logic [31:0] expBusy;
      logic [15:0] expCnt;
   } vec_t;

   vec_t vecs[$];

   regfile_write_arbiter dut (
      .clk(clk), .reset(reset),
      .a_valid(aValid), .a_ready(aReady), .a_addr(aAddr), .a_data(aData),
      .b_valid(bValid), .b_ready(bReady), .b_addr(bAddr), .b_data(bData),
      .rsv_valid(rsvValid), .rsv_addr(rsvAddr), .busy(busy),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .contention_cnt(contentionCnt)
   );

   // Narrow counter copy so saturation is reachable in a handful of cycles.
   regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(3)) satDut (
      .clk(clk), .reset(reset),
      .a_valid(aValid), .a_ready(satAReady), .a_addr(aAddr), .a_data(aData),
      .b_valid(bValid), .b_ready(satBReady), .b_addr(bAddr), .b_data(bData),
      .rsv_valid(rsvValid), .rsv_addr(rsvAddr), .busy(satBusy),
      .wr_en(satWrEn), .wr_addr(satWrAddr), .wr_data(satWrData), .contention_cnt(satCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t makeVec(
      input logic rst, input logic aV, input logic [4:0] aA, input logic [31:0] aD,
      input logic bV, input logic [4:0] bA, input logic [31:0] bD,
      input logic rV, input logic [4:0] rA,
      input logic expAR, input logic expBR, input logic expWrEn,
      input logic [4:0] expWrAddr, input logic [31:0] expWrData,
      input logic [31:0] expBusy, input logic [15:0] expCnt);
      vec_t v;
      v.rst = rst; v.aV = aV; v.aA = aA; v.aD = aD;
      v.bV = bV; v.bA = bA; v.bD = bD; v.rV = rV; v.rA = rA;
      v.expAR = expAR; v.expBR = expBR; v.expWrEn = expWrEn;
      v.expWrAddr = expWrAddr; v.expWrData = expWrData;
      v.expBusy = expBusy; v.expCnt = expCnt;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one vector after the falling edge, check handshakes, then check registered state.
   task automatic applyStimulus(input int idx, input vec_t v);
      @(negedge clk);
      reset = v.rst;
      aValid = v.aV; aAddr = v.aA; aData = v.aD;
      bValid = v.bV; bAddr = v.bA; bData = v.bD;
      rsvValid = v.rV; rsvAddr = v.rA;
      #1;
      checkOutput($sformatf("v%0d.a_ready", idx), 32'(aReady), 32'(v.expAR));
      checkOutput($sformatf("v%0d.b_ready", idx), 32'(bReady), 32'(v.expBR));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.wr_en", idx), 32'(wrEn), 32'(v.expWrEn));
      checkOutput($sformatf("v%0d.wr_addr", idx), 32'(wrAddr), 32'(v.expWrAddr));
      checkOutput($sformatf("v%0d.wr_data", idx), wrData, v.expWrData);
      checkOutput($sformatf("v%0d.busy", idx), busy, v.expBusy);
      checkOutput($sformatf("v%0d.cnt", idx), 32'(contentionCnt), 32'(v.expCnt));
   endtask

   task automatic driveIdle();
      reset = 1'b0;
      aValid = 1'b0; aAddr = '0; aData = '0;
      bValid = 1'b0; bAddr = '0; bData = '0;
      rsvValid = 1'b0; rsvAddr = '0;
   endtask

   initial begin
      int waited;
      driveIdle();

      //                 rst aV aA  aD        bV bA  bD        rV rA  aR bR wrEn wrA wrD       busy        cnt
      vecs.push_back(makeVec(1, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,   0, 0,        0,          0));
      vecs.push_back(makeVec(1, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,   0, 0,        0,          0));
      vecs.push_back(makeVec(0, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,   0, 0,        0,          0));
      vecs.push_back(makeVec(0, 1, 2, 42,      0, 0, 0,       0, 0,  1, 0, 1,   2, 42,       0,          0));
      vecs.push_back(makeVec(0, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,   2, 42,       0,          0));
      vecs.push_back(makeVec(0, 1, 3, 19,      1, 4, 15,      0, 0,  1, 0, 1,   3, 19,       0,          1));
      vecs.push_back(makeVec(0, 0, 0, 0,       1, 4, 15,      0, 0,  0, 1, 1,   4, 15,       0,          1));
      vecs.push_back(makeVec(0, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,   4, 15,       0,          1));
      vecs.push_back(makeVec(0, 1, 8, 'h100,   1, 9, 'h200,   0, 0,  0, 1, 1,   9, 'h200,    0,          2));
      vecs.push_back(makeVec(0, 1, 8, 'h100,   1, 9, 'h201,   0, 0,  1, 0, 1,   8, 'h100,    0,          3));
      vecs.push_back(makeVec(0, 1, 8, 'h101,   1, 9, 'h201,   0, 0,  0, 1, 1,   9, 'h201,    0,          4));
      vecs.push_back(makeVec(0, 1, 8, 'h101,   1, 9, 'h202,   0, 0,  1, 0, 1,   8, 'h101,    0,          5));
      vecs.push_back(makeVec(0, 1, 8, 'h102,   1, 9, 'h202,   0, 0,  0, 1, 1,   9, 'h202,    0,          6));
      vecs.push_back(makeVec(0, 1, 8, 'h102,   1, 9, 'h203,   0, 0,  1, 0, 1,   8, 'h102,    0,          7));
      vecs.push_back(makeVec(0, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,   8, 'h102,    0,          7));
      vecs.push_back(makeVec(0, 0, 0, 0,       0, 0, 0,       1, 17, 0, 0, 0,   8, 'h102,    32'h20000,  7));
      vecs.push_back(makeVec(0, 0, 0, 0,       1, 17, 20,     0, 0,  0, 1, 1,   17, 20,      0,          7));
      vecs.push_back(makeVec(0, 0, 0, 0,       0, 0, 0,       1, 0,  0, 0, 0,   17, 20,      0,          7));
      vecs.push_back(makeVec(0, 1, 0, 'h55,    0, 0, 0,       0, 0,  1, 0, 0,   0, 'h55,     0,          7));
      vecs.push_back(makeVec(0, 1, 5, 'h77,    0, 0, 0,       1, 5,  1, 0, 1,   5, 'h77,     32'h20,     7));
      vecs.push_back(makeVec(0, 1, 6, 'h66,    0, 0, 0,       0, 0,  1, 0, 1,   6, 'h66,     32'h20,     7));
      vecs.push_back(makeVec(1, 1, 9, 'h99,    1, 10, 'hAA,   0, 0,  0, 0, 0,   0, 0,        0,          0));
      vecs.push_back(makeVec(0, 1, 9, 'h99,    1, 10, 'hAA,   0, 0,  1, 0, 1,   9, 'h99,     0,          1));

      foreach (vecs[i]) applyStimulus(i, vecs[i]);

      // Same destination from both requesters: B wins the tie (rr points at B), A follows.
      @(negedge clk);
      driveIdle();
      aValid = 1'b1; aAddr = 5'd12; aData = 32'h1;
      bValid = 1'b1; bAddr = 5'd12; bData = 32'h2;
      #1;
      checkOutput("sameDst.b_ready", 32'(bReady), 32'd1);
      checkOutput("sameDst.a_ready", 32'(aReady), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("sameDst.firstData", wrData, 32'h2);
      @(negedge clk);
      bValid = 1'b0;
      #1;
      waited = 0;
      while (!aReady && waited < 4) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput("sameDst.aGrantInTime", 32'(waited < 4), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("sameDst.lastWrEn", 32'(wrEn), 32'd1);
      checkOutput("sameDst.lastData", wrData, 32'h1);
      @(negedge clk);
      driveIdle();
      @(posedge clk);
      #1;
      checkOutput("sameDst.singlePulse", 32'(wrEn), 32'd0);

      // Sustained contention drives the narrow counter into saturation.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         aValid = 1'b1; aAddr = 5'd13; aData = 32'(i);
         bValid = 1'b1; bAddr = 5'd14; bData = 32'(i + 100);
      end
      @(negedge clk);
      driveIdle();
      #1;
      checkOutput("cnt.main", 32'(contentionCnt), 32'd12);
      checkOutput("cnt.saturated", 32'(satCnt), 32'd7);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
